// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - three-state issue controller driving an external 4-bit ALU over a 4x4 register file
module alu_issue_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_rs1,
  input  logic [1:0] in_rs2,
  input  logic [3:0] in_imm,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [3:0] alu_select,
  input  logic [3:0] alu_out,
  input  logic       alu_c_out,
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [3:0] wb_data,
  output logic       flag_c,
  output logic       flag_z,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;

  logic [4:0] r_op;
  logic [1:0] r_rd;
  logic [1:0] r_rs1;
  logic [1:0] r_rs2;
  logic [3:0] r_imm;
  logic [3:0] r_cap_val;
  logic       r_cap_c;
  logic [3:0] r_regs [0:3];
  logic       r_flag_c;
  logic       r_flag_z;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign flag_c   = r_flag_c;
  assign flag_z   = r_flag_z;
  assign dbg_data = r_regs[dbg_addr];

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state plus all state-decoded outputs (ALU drive and write-back strobe).
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    alu_x      = 4'd0;
    alu_y      = 4'd0;
    alu_select = 4'd0;
    wb_valid   = 1'b0;
    wb_rd      = 2'd0;
    wb_data    = 4'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        alu_x      = r_regs[r_rs1];
        alu_y      = r_regs[r_rs2];
        alu_select = r_op[3:0];
        w_next     = S_WB;
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_rd    = r_rd;
        wb_data  = r_cap_val;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the request fields on acceptance; they stay stable through EXEC and WB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op  <= 5'd0;
      r_rd  <= 2'd0;
      r_rs1 <= 2'd0;
      r_rs2 <= 2'd0;
      r_imm <= 4'd0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_rd  <= in_rd;
      r_rs1 <= in_rs1;
      r_rs2 <= in_rs2;
      r_imm <= in_imm;
    end
  end

  // Capture the result at the end of EXEC; load-immediate bypasses the ALU and drops its carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_val <= 4'd0;
      r_cap_c   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_cap_val <= r_op[4] ? r_imm : alu_out;
      r_cap_c   <= r_op[4] ? 1'b0 : alu_c_out;
    end
  end

  // Commit in WB: register write, zero flag always, carry flag only for arithmetic ops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= 4'd0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (r_state == S_WB) begin
      r_regs[r_rd] <= r_cap_val;
      r_flag_z     <= (r_cap_val == 4'd0);
      if (!r_op[4] && !r_op[3]) r_flag_c <= r_cap_c;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with an external ALU model
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_op;
  logic [1:0] in_rd, in_rs1, in_rs2;
  logic [3:0] in_imm;
  logic [3:0] alu_x, alu_y, alu_select, alu_out;
  logic       alu_c_out;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic       flag_c, flag_z;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_regs [0:3];
  logic       m_c, m_z;

  typedef struct {
    logic [4:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] imm;
    logic [3:0] exp_data;
    logic       exp_c, exp_z;
  } vec_t;

  vec_t tbl [13];

  alu_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_x(alu_x), .alu_y(alu_y), .alu_select(alu_select),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference 4-bit ALU: plain integer arithmetic, returns {carry, result}.
  function automatic logic [4:0] alu_ref(input logic [3:0] sel, input logic [3:0] x, input logic [3:0] y);
    int yy, sum;
    logic [4:0] res;
    if (!sel[3]) begin
      yy  = (sel[2] ? (15 - int'(y)) : 0) | (sel[1] ? int'(y) : 0);
      sum = int'(x) + yy + int'(sel[0]);
      res = {(sum >= 16) ? 1'b1 : 1'b0, 4'(sum % 16)};
    end else begin
      case (sel[1:0])
        2'b00:   res = {1'b0, x & y};
        2'b01:   res = {1'b0, x | y};
        2'b10:   res = {1'b0, x ^ y};
        default: res = {1'b0, 4'(15 - int'(x))};
      endcase
    end
    return res;
  endfunction

  // External combinational ALU seen by the DUT.
  always_comb {alu_c_out, alu_out} = alu_ref(alu_select, alu_x, alu_y);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  // Issue one request and check every cycle through write-back; junk keeps in_valid high with garbage.
  task automatic do_op(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] imm, input bit junk,
                       output logic [3:0] got_wb);
    logic [3:0] x, y, val;
    logic [4:0] r;
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    dbg_addr = rd;
    @(posedge clk); #1;
    if (junk) begin
      in_op = 5'($urandom); in_rd = 2'($urandom); in_rs1 = 2'($urandom);
      in_rs2 = 2'($urandom); in_imm = 4'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    x = m_regs[rs1];
    y = m_regs[rs2];
    chk("ready_exec", in_ready, 0);
    chk("alu_x", alu_x, x);
    chk("alu_y", alu_y, y);
    chk("alu_select", alu_select, op[3:0]);
    chk("wb_valid_exec", wb_valid, 0);
    r   = alu_ref(op[3:0], x, y);
    val = op[4] ? imm : r[3:0];
    @(posedge clk); #1;
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, rd);
    chk("wb_data", wb_data, val);
    chk("ready_wb", in_ready, 0);
    chk("alu_x_wb", alu_x, 0);
    chk("alu_select_wb", alu_select, 0);
    got_wb = wb_data;
    m_regs[rd] = val;
    m_z = (val == 4'd0);
    if (!op[4] && !op[3]) m_c = r[4];
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("wb_valid_after", wb_valid, 0);
    chk("wb_rd_idle", wb_rd, 0);
    chk("wb_data_idle", wb_data, 0);
    chk("flag_c", flag_c, m_c);
    chk("flag_z", flag_z, m_z);
    chk("dbg_rd", dbg_data, m_regs[rd]);
  endtask

  logic [3:0] got;
  bit         acc [0:20];
  int         n_acc;

  initial begin
    tbl[0]  = '{5'h10, 2'd1, 2'd0, 2'd0, 4'h9, 4'h9, 1'b0, 1'b0};
    tbl[1]  = '{5'h10, 2'd2, 2'd0, 2'd0, 4'h8, 4'h8, 1'b0, 1'b0};
    tbl[2]  = '{5'h02, 2'd3, 2'd1, 2'd2, 4'h0, 4'h1, 1'b1, 1'b0};
    tbl[3]  = '{5'h10, 2'd1, 2'd0, 2'd0, 4'h5, 4'h5, 1'b1, 1'b0};
    tbl[4]  = '{5'h10, 2'd2, 2'd0, 2'd0, 4'h5, 4'h5, 1'b1, 1'b0};
    tbl[5]  = '{5'h05, 2'd0, 2'd1, 2'd2, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[6]  = '{5'h10, 2'd1, 2'd0, 2'd0, 4'hC, 4'hC, 1'b1, 1'b0};
    tbl[7]  = '{5'h10, 2'd2, 2'd0, 2'd0, 4'hA, 4'hA, 1'b1, 1'b0};
    tbl[8]  = '{5'h0A, 2'd1, 2'd1, 2'd2, 4'h0, 4'h6, 1'b1, 1'b0};
    tbl[9]  = '{5'h10, 2'd2, 2'd0, 2'd0, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[10] = '{5'h01, 2'd2, 2'd2, 2'd0, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[11] = '{5'h02, 2'd3, 2'd1, 2'd2, 4'h0, 4'h6, 1'b0, 1'b0};
    tbl[12] = '{5'h0B, 2'd0, 2'd1, 2'd2, 4'h0, 4'h9, 1'b0, 1'b0};

    reset_n = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_imm = '0; dbg_addr = '0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_alu_select", alu_select, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_dbg", dbg_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("rel_ready", in_ready, 1);

    // Directed table: fixed expected results for the documented scenarios.
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b0, got);
      chk($sformatf("tbl%0d_wb_data", i), got, tbl[i].exp_data);
      chk($sformatf("tbl%0d_reg", i), dbg_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_flag_c", i), flag_c, tbl[i].exp_c);
      chk($sformatf("tbl%0d_flag_z", i), flag_z, tbl[i].exp_z);
    end

    // Continuous in_valid: accepts every third cycle, each write-back two cycles later.
    n_acc = 0;
    in_op = 5'h10; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0; dbg_addr = 2'd0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      in_valid = (c < 18);
      in_imm   = 4'(c);
      acc[c]   = in_valid && in_ready;
      if (acc[c]) n_acc++;
      if (c < 18) chk($sformatf("hold_ready_c%0d", c), in_ready, (c % 3 == 0) ? 1 : 0);
      if (c >= 2) begin
        chk($sformatf("hold_wb_c%0d", c), wb_valid, acc[c-2] ? 1 : 0);
        if (acc[c-2]) chk($sformatf("hold_wb_data_c%0d", c), wb_data, (c - 2) % 16);
      end
    end
    in_valid = 1'b0;
    chk("hold_accepts", n_acc, 6);
    m_regs[0] = 4'd15; m_z = 1'b0;
    #1 chk("hold_r0", dbg_data, 15);

    // Reset during EXEC of load-immediate R2 <- 0xF.
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'h10; in_rd = 2'd2; in_imm = 4'hF; dbg_addr = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_wb_rd", wb_rd, 0);
    chk("abort_wb_data", wb_data, 0);
    chk("abort_alu_x", alu_x, 0);
    chk("abort_alu_y", alu_y, 0);
    chk("abort_alu_select", alu_select, 0);
    chk("abort_flag_c", flag_c, 0);
    chk("abort_flag_z", flag_z, 0);
    chk("abort_r2", dbg_data, 0);
    @(negedge clk);
    chk("abort_wb_later", wb_valid, 0);
    reset_n = 1'b1;
    #1 chk("abort_ready", in_ready, 1);
    @(negedge clk) chk("abort_no_wb", wb_valid, 0);
    chk("abort_r2_after", dbg_data, 0);

    // Reset during WB: the write must not land.
    in_valid = 1'b1; in_op = 5'h10; in_rd = 2'd1; in_imm = 4'h7; dbg_addr = 2'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wbabort_in_wb", wb_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("wbabort_wb_valid", wb_valid, 0);
    chk("wbabort_r1", dbg_data, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) chk("wbabort_r1_after", dbg_data, 0);

    // Randomized operations against the model, sometimes with in_valid held high while busy.
    for (int i = 0; i < 40; i++) begin
      do_op(5'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
            bit'($urandom_range(0, 1)), got);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk($sformatf("final_r%0d", i), dbg_data, m_regs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
